// File: rtl/interboard_tx_queue.sv
// Transmit side of the inter-board link: queues GameControl messages and sends each one as two 6-bit
// words over a 4-phase Request/Ack handshake. Optional handshake timeout: define INTERBOARD_TX_TIMEOUT_EN.
module interboard_tx_queue #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       ctrl_en,
    input  logic [2:0] ctrl_msg_type,
    input  logic [4:0] ctrl_number,
    input  logic       Ack_in,
    output logic       inter_ready,
    output logic       Request_out,
    output logic [5:0] inter_data_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overflow,
    output logic       tx_timeout
);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ0 = 3'd1;
    localparam logic [2:0] S_REL0 = 3'd2;
    localparam logic [2:0] S_REQ1 = 3'd3;
    localparam logic [2:0] S_REL1 = 3'd4;

    // MSB of each word tells the receiver which half it is; neither form can reach 6'h3f.
    function automatic logic [5:0] enc_w0(input logic [4:0] type_hi);
        return {1'b0, type_hi};
    endfunction

    function automatic logic [5:0] enc_w1(input logic [2:0] num_lo);
        return {1'b1, 2'b00, num_lo};
    endfunction

    logic rst_all;
    assign rst_all = rst | interboard_rst;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          overflow_q;
    logic          full, empty, push, pop;
    logic [7:0]    head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = ctrl_en && !full;
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ctrl_msg_type, ctrl_number};
    end

    // A push arriving at full is dropped even when the FSM pops in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (ctrl_en && full) overflow_q <= 1'b1;
        end
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    assign ack_s = sync_q[SYNC_STAGES-1];

    logic [2:0] state_q, state_d;
    logic       req_q, req_d;
    logic [5:0] data_q, data_d;
    logic       done_q, done_d;
    logic [2:0] lo_q;

`ifdef INTERBOARD_TX_TIMEOUT_EN
    localparam int          TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
    logic          tmo_hit;
    assign tmo_hit = (state_q != S_IDLE) && (tcnt_q == T_LAST);
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (!empty) begin
                pop     = 1'b1;
                data_d  = enc_w0(head[7:3]);
                req_d   = 1'b1;
                state_d = S_REQ0;
            end
            S_REQ0: if (ack_s) begin
                req_d   = 1'b0;
                state_d = S_REL0;
            end
            S_REL0: if (!ack_s) begin
                data_d  = enc_w1(lo_q);
                req_d   = 1'b1;
                state_d = S_REQ1;
            end
            S_REQ1: if (ack_s) begin
                req_d   = 1'b0;
                state_d = S_REL1;
            end
            S_REL1: if (!ack_s) begin
                data_d  = '0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef INTERBOARD_TX_TIMEOUT_EN
        // Abandon only the message in flight; anything still queued goes next.
        tmo_d = 1'b0;
        if (tmo_hit) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            data_d  = '0;
            done_d  = 1'b0;
            tmo_d   = 1'b1;
        end
        tcnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : tcnt_q + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], Ack_in};
        end
    end

    always_ff @(posedge clk) begin
        if (pop) lo_q <= head[2:0];
    end

`ifdef INTERBOARD_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst_all) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
    assign tx_timeout = tmo_q;
`else
    assign tx_timeout = 1'b0;
`endif

    assign inter_ready    = !full;
    assign Request_out    = req_q;
    assign inter_data_out = data_q;
    assign tx_busy        = (state_q != S_IDLE) || !empty;
    assign tx_done        = done_q;
    assign tx_overflow    = overflow_q;

endmodule

// File: tb/tb_interboard_tx_queue.sv
// Directed + randomized bench for interboard_tx_queue with an acting responder on the Ack side.
module tb_interboard_tx_queue;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
`ifdef INTERBOARD_TX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1_000_000;
`endif

    logic       clk, rst, interboard_rst, ctrl_en, Ack_in;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic       inter_ready, Request_out, tx_busy, tx_done, tx_overflow, tx_timeout;
    logic [5:0] inter_data_out;

    int checks = 0;
    int failures = 0;

    interboard_tx_queue #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .ctrl_en(ctrl_en),
        .ctrl_msg_type(ctrl_msg_type), .ctrl_number(ctrl_number), .Ack_in(Ack_in),
        .inter_ready(inter_ready), .Request_out(Request_out), .inter_data_out(inter_data_out),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_overflow(tx_overflow), .tx_timeout(tx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference encoding from the word layout: first word carries type and number/8, second number%8.
    function automatic logic [5:0] exp_w0(input logic [7:0] m);
        int t, n;
        t = int'(m[7:5]);
        n = int'(m[4:0]);
        return 6'(t * 4 + n / 8);
    endfunction

    function automatic logic [5:0] exp_w1(input logic [7:0] m);
        int n;
        n = int'(m[4:0]);
        return 6'(32 + n % 8);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (Request_out === v) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (tx_done === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ctrl_en = 1'b0;
        Ack_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_msg(input logic [7:0] m);
        ctrl_msg_type = m[7:5];
        ctrl_number   = m[4:0];
        ctrl_en       = 1'b1;
        tick();
        ctrl_en       = 1'b0;
    endtask

    task automatic respond(input logic [7:0] m, input int dly);
        bit ok;
        logic [5:0] w;
        wait_req(1'b1, ok);
        check("req_w0", 32'(ok), 1);
        w = inter_data_out;
        check("w0", 32'(w), 32'(exp_w0(m)));
        check("w0_not3f", 32'(w == 6'h3f), 0);
        repeat (dly) tick();
        Ack_in = 1'b1;
        wait_req(1'b0, ok);
        check("rel_w0", 32'(ok), 1);
        check("w0_held", 32'(inter_data_out), 32'(exp_w0(m)));
        Ack_in = 1'b0;
        wait_req(1'b1, ok);
        check("req_w1", 32'(ok), 1);
        w = inter_data_out;
        check("w1", 32'(w), 32'(exp_w1(m)));
        check("w1_not3f", 32'(w == 6'h3f), 0);
        repeat (dly) tick();
        Ack_in = 1'b1;
        wait_req(1'b0, ok);
        check("rel_w1", 32'(ok), 1);
        Ack_in = 1'b0;
        wait_done(ok);
        check("done", 32'(ok), 1);
        check("done_data0", 32'(inter_data_out), 0);
        tick();
        check("done_pulse", 32'(tx_done), 0);
        check("no_tmo", 32'(tx_timeout), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] m;
        bit ok;
        int hi, k, bad;

        rst = 1'b1; interboard_rst = 1'b0; ctrl_en = 1'b0; Ack_in = 1'b0;
        ctrl_msg_type = '0; ctrl_number = '0;

        // Reset state
        do_reset();
        check("rst_req", 32'(Request_out), 0);
        check("rst_data", 32'(inter_data_out), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_ovf", 32'(tx_overflow), 0);
        check("rst_tmo", 32'(tx_timeout), 0);
        check("rst_ready", 32'(inter_ready), 1);
        check("rst_busy", 32'(tx_busy), 0);

        // Single message type=2 num=21 with latency checks
        ctrl_msg_type = 3'd2; ctrl_number = 5'd21; ctrl_en = 1'b1;
        tick();
        ctrl_en = 1'b0;
        check("lat_c1_req", 32'(Request_out), 0);
        check("lat_c1_busy", 32'(tx_busy), 1);
        tick();
        check("lat_c2_req", 32'(Request_out), 1);
        check("t1_w0", 32'(inter_data_out), 32'(6'b001010));
        Ack_in = 1'b1;
        tick(); tick();
        check("ack_n2_req", 32'(Request_out), 1);
        tick();
        check("ack_n3_req", 32'(Request_out), 0);
        Ack_in = 1'b0;
        wait_req(1'b1, ok);
        check("t1_req_w1", 32'(ok), 1);
        check("t1_w1", 32'(inter_data_out), 32'(6'b100101));
        Ack_in = 1'b1;
        wait_req(1'b0, ok);
        Ack_in = 1'b0;
        wait_done(ok);
        check("t1_done", 32'(ok), 1);
        tick();
        check("t1_done_pulse", 32'(tx_done), 0);
        check("t1_busy_fall", 32'(tx_busy), 0);

        // Extreme values type=7 num=31
        do_reset();
        push_msg({3'd7, 5'd31});
        respond({3'd7, 5'd31}, 1);

        // Fill while the head message is stuck, then overflow
        do_reset();
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom_range(0, 255)));
        push_msg(q[0]);
        tick(); tick(); tick();
        for (int i = 1; i <= 4; i++) begin
            push_msg(q[i]);
            check("fill_ready", 32'(inter_ready), 32'(i < 4));
        end
        check("fill_no_ovf", 32'(tx_overflow), 0);
        push_msg(q[5]);
        check("ovf_set", 32'(tx_overflow), 1);
        check("ovf_ready", 32'(inter_ready), 0);
        for (int i = 0; i < 5; i++) respond(q[i], $urandom_range(0, 3));
        check("ovf_drained_ready", 32'(inter_ready), 1);
        check("ovf_drained_busy", 32'(tx_busy), 0);
        check("ovf_sticky", 32'(tx_overflow), 1);

        // Push at full in the same cycle as a pop is still dropped
        do_reset();
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom_range(0, 255)));
        push_msg(q[0]);
        tick(); tick(); tick();
        for (int i = 1; i < 5; i++) push_msg(q[i]);
        check("pp_full", 32'(inter_ready), 0);
        wait_req(1'b1, ok);
        Ack_in = 1'b1; wait_req(1'b0, ok); Ack_in = 1'b0;
        wait_req(1'b1, ok);
        Ack_in = 1'b1; wait_req(1'b0, ok); Ack_in = 1'b0;
        wait_done(ok);
        check("pp_done", 32'(ok), 1);
        ctrl_msg_type = 3'd5; ctrl_number = 5'd9; ctrl_en = 1'b1;
        tick();
        ctrl_en = 1'b0;
        check("pp_ovf", 32'(tx_overflow), 1);
        check("pp_ready", 32'(inter_ready), 1);
        check("pp_next_req", 32'(Request_out), 1);
        for (int i = 1; i < 5; i++) respond(q[i], $urandom_range(0, 2));
        repeat (5) tick();
        check("pp_dropped_absent", 32'(Request_out), 0);
        check("pp_idle", 32'(tx_busy), 0);

        // interboard_rst while sending the second word with two messages queued
        do_reset();
        push_msg(8'h11); push_msg(8'h22); push_msg(8'h33);
        wait_req(1'b1, ok);
        Ack_in = 1'b1; wait_req(1'b0, ok); Ack_in = 1'b0;
        wait_req(1'b1, ok);
        check("ibr_in_req1", 32'(inter_data_out), 32'(exp_w1(8'h11)));
        interboard_rst = 1'b1;
        tick();
        interboard_rst = 1'b0;
        check("ibr_req", 32'(Request_out), 0);
        check("ibr_data", 32'(inter_data_out), 0);
        check("ibr_busy", 32'(tx_busy), 0);
        check("ibr_done", 32'(tx_done), 0);
        bad = 0;
        repeat (6) begin
            tick();
            if (Request_out !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        check("ibr_quiet", 32'(bad), 0);

        // Ack already high: request accepted as soon as it is seen; live responder takes SYNC+1 cycles
        do_reset();
        Ack_in = 1'b1;
        tick(); tick(); tick();
        m = 8'($urandom_range(0, 255));
        push_msg(m);
        wait_req(1'b1, ok);
        check("pre_w0", 32'(inter_data_out), 32'(exp_w0(m)));
        hi = 0;
        while (Request_out === 1'b1 && hi < 20) begin hi++; tick(); end
        check("pre_hi_cycles", 32'(hi), 1);
        Ack_in = 1'b0;
        wait_req(1'b1, ok);
        check("pre_w1", 32'(inter_data_out), 32'(exp_w1(m)));
        Ack_in = 1'b1;
        hi = 0;
        while (Request_out === 1'b1 && hi < 20) begin hi++; tick(); end
        check("live_hi_cycles", 32'(hi), SYNC + 1);
        Ack_in = 1'b0;
        wait_done(ok);
        check("pre_done", 32'(ok), 1);

        // Randomized batches, delivered in order
        do_reset();
        for (int b = 0; b < 10; b++) begin
            q.delete();
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                m = 8'($urandom_range(0, 255));
                q.push_back(m);
                push_msg(m);
            end
            for (int i = 0; i < k; i++) respond(q[i], $urandom_range(0, 3));
        end
        check("rand_no_ovf", 32'(tx_overflow), 0);
        check("rand_idle", 32'(tx_busy), 0);

`ifdef INTERBOARD_TX_TIMEOUT_EN
        // Ack stuck low: first message abandoned after TO cycles, queued one follows
        do_reset();
        push_msg(8'h45); push_msg(8'hA6);
        wait_req(1'b1, ok);
        hi = 0;
        while (tx_timeout !== 1'b1 && hi < 40) begin hi++; tick(); end
        check("tmo_cycles", 32'(hi), TO);
        check("tmo_req", 32'(Request_out), 0);
        check("tmo_data", 32'(inter_data_out), 0);
        tick();
        check("tmo_pulse", 32'(tx_timeout), 0);
        check("tmo_next_req", 32'(Request_out), 1);
        check("tmo_next_w0", 32'(inter_data_out), 32'(exp_w0(8'hA6)));
        respond(8'hA6, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
